// File: rtl/fifo_sched.sv
// fifo_sched: round-robin write arbiter for NREQ requesters feeding an external FIFO,
// plus a two-state read FSM that drains the FIFO through a valid/ready port.
module fifo_sched #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    fifo_write,
  output logic [WIDTH-1:0]        fifo_data_in,
  output logic                    fifo_read,
  input  logic [WIDTH-1:0]        fifo_data_out,
  input  logic                    fifo_full,
  input  logic                    fifo_empty,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready,
  output logic [15:0]             wr_count
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_VALID = 1'b1
  } rd_state_e;

  rd_state_e     rd_state_q, rd_state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [15:0]   wr_count_q, wr_count_d;

  logic [IW-1:0] sel;
  logic [IW-1:0] idx;
  logic          hit;
  logic          any_valid;
  logic          write_allowed;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (v == IW'(NREQ - 1)) begin
      return {IW{1'b0}};
    end else begin
      return v + IW'(1);
    end
  endfunction

  // Round-robin search: first valid requester at or above rr_ptr, modulo NREQ.
  always_comb begin
    sel       = rr_ptr_q;
    any_valid = 1'b0;
    idx       = rr_ptr_q;
    hit       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      hit       = !any_valid && req_valid[idx];
      sel       = hit ? idx : sel;
      any_valid = any_valid | hit;
      idx       = wrap_inc(idx);
    end
  end

  // Read FSM: one fifo_read per word, then present it until the consumer takes it.
  always_comb begin
    rd_state_d = rd_state_q;
    fifo_read  = 1'b0;
    out_valid  = 1'b0;
    out_data   = {WIDTH{1'b0}};
    case (rd_state_q)
      RD_IDLE: begin
        fifo_read  = !rst && !fifo_empty;
        rd_state_d = fifo_read ? RD_VALID : RD_IDLE;
      end
      RD_VALID: begin
        out_valid  = !rst;
        out_data   = rst ? {WIDTH{1'b0}} : fifo_data_out;
        rd_state_d = out_ready ? RD_IDLE : RD_VALID;
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  // Write path: reads win the FIFO port, and a full FIFO blocks in the same cycle.
  always_comb begin
    write_allowed  = !rst && !fifo_full && !fifo_read;
    req_ready      = {NREQ{1'b0}};
    req_ready[sel] = write_allowed && any_valid;
    fifo_write     = |req_ready;
    fifo_data_in   = req_data[int'(sel)*WIDTH +: WIDTH];
    rr_ptr_d       = fifo_write ? wrap_inc(sel) : rr_ptr_q;
    wr_count_d     = wr_count_q + (fifo_write ? 16'd1 : 16'd0);
    grant_id       = rst ? {IW{1'b0}} : (any_valid ? sel : grant_q);
    grant_d        = grant_id;
    wr_count       = rst ? 16'd0 : wr_count_q;
  end

  // State registers with synchronous reset; FIFO contents are not ours to clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      rr_ptr_q   <= {IW{1'b0}};
      grant_q    <= {IW{1'b0}};
      wr_count_q <= 16'd0;
    end else begin
      rd_state_q <= rd_state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      wr_count_q <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_sched.sv
// Directed testbench for fifo_sched with a small behavioural FIFO (registered read data).
module tb_fifo_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [1:0]   grant_id;
  logic         fifo_write;
  logic [31:0]  fifo_data_in;
  logic         fifo_read;
  logic [31:0]  fifo_data_out = 32'h0;
  logic         fifo_full;
  logic         fifo_empty;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_ready;
  logic [15:0]  wr_count;

  logic         force_full;
  logic         fifo_flush;
  int           checks = 0;
  int           passes = 0;

  logic [31:0]  mem [16];
  int           wp = 0;
  int           rp = 0;
  int           cnt = 0;

  fifo_sched #(.WIDTH(32), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant_id(grant_id), .fifo_write(fifo_write),
    .fifo_data_in(fifo_data_in), .fifo_read(fifo_read), .fifo_data_out(fifo_data_out),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (cnt == 0);
  assign fifo_full  = force_full || (cnt == 16);

  // Behavioural FIFO; only the bench-side flush clears it, never rst.
  always @(posedge clk) begin
    if (fifo_flush) begin
      wp <= 0; rp <= 0; cnt <= 0;
    end else begin
      if (fifo_write && cnt < 16) begin
        mem[wp % 16] <= fifo_data_in;
        wp <= wp + 1;
      end
      if (fifo_read && cnt > 0) begin
        fifo_data_out <= mem[rp % 16];
        rp <= rp + 1;
      end
      cnt <= cnt + ((fifo_write && cnt < 16) ? 1 : 0) - ((fifo_read && cnt > 0) ? 1 : 0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; fifo_flush = 1'b1; req_valid = 4'b0000; force_full = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; fifo_flush = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b expected %b", req_ready, 4'b0000); else passes++;
    checks++; if (fifo_write !== 1'b0) $display("FAIL rst_write: got %b expected 0", fifo_write); else passes++;
    checks++; if (fifo_read !== 1'b0) $display("FAIL rst_read: got %b expected 0", fifo_read); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (grant_id !== 2'd0) $display("FAIL rst_grant: got %0d expected 0", grant_id); else passes++;
    checks++; if (wr_count !== 16'd0) $display("FAIL rst_wr_count: got %0d expected 0", wr_count); else passes++;
    @(negedge clk);
    rst = 1'b0; fifo_flush = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL first_grant: got %b expected %b", req_ready, 4'b0001); else passes++;
    checks++; if (grant_id !== 2'd0) $display("FAIL first_grant_id: got %0d expected 0", grant_id); else passes++;
  endtask

  task automatic test_single();
    do_reset();
    req_data = 128'h0; req_data[31:0] = 32'hA5A5A5A5; req_valid = 4'b0001; out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b expected %b", req_ready, 4'b0001); else passes++;
    checks++; if (fifo_write !== 1'b1) $display("FAIL single_write: got %b expected 1", fifo_write); else passes++;
    checks++; if (fifo_data_in !== 32'hA5A5A5A5) $display("FAIL single_wdata: got %h expected a5a5a5a5", fifo_data_in); else passes++;
    checks++; if (fifo_read !== 1'b0) $display("FAIL single_noread: got %b expected 0", fifo_read); else passes++;
    @(negedge clk); req_valid = 4'b0000; #1;
    checks++; if (fifo_read !== 1'b1) $display("FAIL single_read: got %b expected 1", fifo_read); else passes++;
    checks++; if (fifo_write !== 1'b0) $display("FAIL single_write_blocked: got %b expected 0", fifo_write); else passes++;
    checks++; if (wr_count !== 16'd1) $display("FAIL single_wr_count: got %0d expected 1", wr_count); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL single_out_early: got %b expected 0", out_valid); else passes++;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 32'hA5A5A5A5) $display("FAIL single_out_data: got %h expected a5a5a5a5", out_data); else passes++;
    checks++; if (fifo_read !== 1'b0) $display("FAIL single_read_hold: got %b expected 0", fifo_read); else passes++;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL single_out_done: got %b expected 0", out_valid); else passes++;
  endtask

  task automatic test_fairness();
    int          per_req [4];
    int          n;
    logic [31:0] q [$];
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < 4; i++) per_req[i] = 0;
    n = 0;
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      checks++; if ((fifo_write & fifo_read) !== 1'b0) $display("FAIL fair_collision: cycle %0d write %b read %b", c, fifo_write, fifo_read); else passes++;
      if (out_valid) begin
        exp_d = (q.size() > 0) ? q.pop_front() : 32'hFFFF_FFFF;
        checks++; if (out_data !== exp_d) $display("FAIL fair_out_data: got %h expected %h", out_data, exp_d); else passes++;
      end
      if (fifo_write) begin
        checks++; if (req_ready !== 4'(4'b0001 << (n % 4))) $display("FAIL fair_order: write %0d got %b expected %b", n, req_ready, 4'(4'b0001 << (n % 4))); else passes++;
        per_req[grant_id]++;
        q.push_back(32'h1000_0000 + 32'(n % 4));
        n++;
      end
      @(negedge clk);
    end
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      checks++; if (per_req[i] !== 5) $display("FAIL fair_count: requester %0d got %0d expected 5", i, per_req[i]); else passes++;
    end
    checks++; if (wr_count !== 16'd20) $display("FAIL fair_wr_count: got %0d expected 20", wr_count); else passes++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hF000_0000 + 32'(i);
    req_valid = 4'b0001; out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL full_pre: got %b expected %b", req_ready, 4'b0001); else passes++;
    @(negedge clk); force_full = 1'b1; req_valid = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) $display("FAIL full_ready: cycle %0d got %b expected 0000", c, req_ready); else passes++;
      checks++; if (fifo_write !== 1'b0) $display("FAIL full_write: cycle %0d got %b expected 0", c, fifo_write); else passes++;
      checks++; if (grant_id !== 2'd1) $display("FAIL full_grant: cycle %0d got %0d expected 1", c, grant_id); else passes++;
      @(negedge clk);
    end
    force_full = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) $display("FAIL full_release: got %b expected %b", req_ready, 4'b0010); else passes++;
    checks++; if (fifo_data_in !== 32'hF000_0001) $display("FAIL full_release_data: got %h expected f0000001", fifo_data_in); else passes++;
    @(negedge clk); req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_data = 128'h0;
    req_data[64 +: 32] = 32'h1234_5678; req_data[96 +: 32] = 32'hDEAD_BEEF;
    req_valid = 4'b0100; out_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) $display("FAIL bp_first_write: got %b expected %b", req_ready, 4'b0100); else passes++;
    @(negedge clk); req_valid = 4'b0000; #1;
    checks++; if (fifo_read !== 1'b1) $display("FAIL bp_read: got %b expected 1", fifo_read); else passes++;
    @(negedge clk); req_valid = 4'b1000; #1;
    checks++; if (req_ready !== 4'b1000) $display("FAIL bp_write_during_valid: got %b expected %b", req_ready, 4'b1000); else passes++;
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid: cycle %0d got %b expected 1", c, out_valid); else passes++;
      checks++; if (out_data !== 32'h1234_5678) $display("FAIL bp_data: cycle %0d got %h expected 12345678", c, out_data); else passes++;
      checks++; if (fifo_read !== 1'b0) $display("FAIL bp_noread: cycle %0d got %b expected 0", c, fifo_read); else passes++;
      @(negedge clk); req_valid = 4'b0000; #1;
    end
    out_ready = 1'b1; #1;
    checks++; if (out_data !== 32'h1234_5678) $display("FAIL bp_deliver: got %h expected 12345678", out_data); else passes++;
    @(negedge clk); #1;
    checks++; if (fifo_read !== 1'b1) $display("FAIL bp_next_read: got %b expected 1", fifo_read); else passes++;
    checks++; if (wr_count !== 16'd2) $display("FAIL bp_wr_count: got %0d expected 2", wr_count); else passes++;
    @(negedge clk); #1;
    checks++; if (out_data !== 32'hDEAD_BEEF) $display("FAIL bp_second_word: got %h expected deadbeef", out_data); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hC000_0000 + 32'(i);
    req_valid = 4'b0111; out_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL mid_w0: got %b expected %b", req_ready, 4'b0001); else passes++;
    @(negedge clk); #1;
    checks++; if (fifo_read !== 1'b1) $display("FAIL mid_read: got %b expected 1", fifo_read); else passes++;
    @(negedge clk); #1;
    checks++; if (req_ready !== 4'b0010) $display("FAIL mid_w1: got %b expected %b", req_ready, 4'b0010); else passes++;
    @(negedge clk); #1;
    checks++; if (req_ready !== 4'b0100) $display("FAIL mid_w2: got %b expected %b", req_ready, 4'b0100); else passes++;
    @(negedge clk); req_valid = 4'b0000; #1;
    checks++; if (out_valid !== 1'b1) $display("FAIL mid_pending: got %b expected 1", out_valid); else passes++;
    checks++; if (wr_count !== 16'd3) $display("FAIL mid_wr_count: got %0d expected 3", wr_count); else passes++;
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (wr_count !== 16'd0) $display("FAIL mid_rst_count: got %0d expected 0", wr_count); else passes++;
    checks++; if (fifo_read !== 1'b0) $display("FAIL mid_rst_read: got %b expected 0", fifo_read); else passes++;
    @(negedge clk); rst = 1'b0; req_valid = 4'b1111; out_ready = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_after_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (wr_count !== 16'd0) $display("FAIL mid_after_count: got %0d expected 0", wr_count); else passes++;
    checks++; if (grant_id !== 2'd0) $display("FAIL mid_after_ptr: got %0d expected 0", grant_id); else passes++;
    checks++; if (fifo_read !== 1'b1) $display("FAIL mid_after_read: got %b expected 1", fifo_read); else passes++;
    @(negedge clk); #1;
    checks++; if (out_data !== 32'hC000_0001) $display("FAIL mid_next_word: got %h expected c0000001", out_data); else passes++;
    checks++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b expected %b", req_ready, 4'b0001); else passes++;
    @(negedge clk); req_valid = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; fifo_flush = 1'b1; force_full = 1'b0; out_ready = 1'b1;
    req_valid = 4'b0000; req_data = 128'h0;
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sched.md
FIFO_SCHED -- requirements
Module: fifo_sched

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset: clk (rising edge) and rst, with rst sampled only on the rising edge of clk.
REQ-002 Parameter WIDTH SHALL default to 32 and set the data word width.
REQ-003 Parameter NREQ SHALL default to 4 and set the number of write requesters (2..8).
REQ-004 Port clk SHALL be an input, 1 bit wide, and is the system clock.
REQ-005 Port rst SHALL be an input, 1 bit wide, and is the synchronous active-high reset.
REQ-006 Port req_valid SHALL be an input, NREQ bits wide; bit i means requester i offers a word.
REQ-007 Port req_data SHALL be an input, NREQ*WIDTH bits wide; slice [i*WIDTH +: WIDTH] is requester i's word.
REQ-008 Port req_ready SHALL be an output, NREQ bits wide; bit i means requester i's word is accepted this cycle.
REQ-009 Port grant_id SHALL be an output, $clog2(NREQ) bits wide, and is the index of the requester currently granted.
REQ-010 Port fifo_write SHALL be an output, 1 bit wide, and drives the FIFO write enable.
REQ-011 Port fifo_data_in SHALL be an output, WIDTH bits wide, and drives the FIFO write data.
REQ-012 Port fifo_read SHALL be an output, 1 bit wide, and drives the FIFO read enable.
REQ-013 Port fifo_data_out SHALL be an input, WIDTH bits wide, carrying FIFO read data registered 1 cycle after fifo_read.
REQ-014 Ports fifo_full and fifo_empty SHALL be inputs, 1 bit wide each, and are the FIFO status flags.
REQ-015 Ports out_valid (output, 1 bit), out_data (output, WIDTH bits) and out_ready (input, 1 bit) SHALL form the drain-side handshake.
REQ-016 Port wr_count SHALL be an output, 16 bits wide, counting accepted writes.

Function
REQ-017 The block SHALL never assert fifo_write and fifo_read in the same cycle, because the FIFO count logic is undefined under simultaneous access.
REQ-018 The read FSM SHALL have two states, RD_IDLE and RD_VALID.
REQ-019 In RD_IDLE with fifo_empty=0, the block SHALL assert fifo_read for exactly 1 cycle and move to RD_VALID on the next edge.
REQ-020 In RD_VALID, out_valid SHALL be 1 and out_data SHALL equal fifo_data_out; fifo_read SHALL stay 0 until the state returns to RD_IDLE.
REQ-021 In RD_VALID with out_ready=1, the block SHALL complete the transfer and return to RD_IDLE on the next edge; with out_ready=0, it SHALL hold out_valid and out_data stable.
REQ-022 Sustained drain throughput SHALL be at most 1 word per 2 cycles.
REQ-023 A read issued in a cycle SHALL take priority, and write_allowed SHALL equal !fifo_full && !fifo_read.
REQ-024 The write arbiter SHALL be round-robin: the granted requester is the first i with req_valid[i]=1, searching from pointer rr_ptr upward modulo NREQ.
REQ-025 req_ready[g] SHALL be 1 only for the granted index g, only when write_allowed=1, and only when req_valid[g]=1; every other bit SHALL be 0.
REQ-026 fifo_write SHALL equal |req_ready, and fifo_data_in SHALL equal req_data slice g.
REQ-027 After an accepted write from g, rr_ptr SHALL become (g+1) mod NREQ; with no accepted write, rr_ptr SHALL hold.
REQ-028 grant_id SHALL show g whenever any req_valid bit is set; otherwise it SHALL hold its last value.
REQ-029 A blocked write (full or read-priority) SHALL leave rr_ptr unchanged, so the same requester wins the next allowed cycle.
REQ-030 wr_count SHALL increment by 1 per accepted write and wrap from 0xFFFF to 0x0000.
REQ-031 fifo_full SHALL be honoured combinationally in the same cycle, with no write issued while it is 1.
REQ-032 fifo_empty SHALL be sampled only in RD_IDLE.

Reset
REQ-033 While rst=1, the block SHALL hold the read FSM in RD_IDLE, rr_ptr=0, grant_id=0, wr_count=0, and req_ready, fifo_write, fifo_read and out_valid at 0.
REQ-034 A reset asserted in RD_VALID SHALL drop the pending word without reading it again; FIFO storage is not cleared by rst.
REQ-035 The first grant after reset SHALL go to requester 0 when req_valid[0]=1.

Verification
REQ-036 Scenario (single requester): with req_valid=0001, data 0xA5A5A5A5, and the FIFO empty -> 1 write, then fifo_read one cycle later, out_valid with 0xA5A5A5A5 on the next cycle, and wr_count=1.
REQ-037 Scenario (fairness): with all 4 requesters continuously valid and out_ready=1 -> grants cycle in order 0,1,2,3,0; each requester gets equal writes over 40 cycles.
REQ-038 Scenario (full): with fifo_full held at 1 and requesters valid -> req_ready=0 and fifo_write=0; when full clears, the previously granted index is accepted first.
REQ-039 Scenario (no collision): across random traffic, fifo_write & fifo_read is never 1 in any cycle (assertion).
REQ-040 Scenario (backpressure): out_ready=0 for 5 cycles in RD_VALID -> out_data stable, fifo_read=0, and the word is delivered intact once out_ready=1.
REQ-041 Scenario (reset mid-operation): rst asserted in RD_VALID after 3 writes -> all outputs return to reset values next cycle, with wr_count=0 and rr_ptr=0.
